// File: rtl/clock_pkg.sv
// Shared definitions for the digital-clock time fields.
// Contents:
//   bcd_nibble_t              one BCD digit (0..9 when valid)
//   SEC_MAX, HR24_MAX,
//   HR12_MIN, HR12_MAX        standard field bounds (decimal)
//   bcd_inc / bcd_dec         single-digit 0..9 step with wrap
//   bin_to_bcd8               decimal 0..99 to packed {tens, ones}
//   bcd8_valid                both nibbles of a packed byte are 0..9
package clock_pkg;

  typedef logic [3:0] bcd_nibble_t;

  localparam int unsigned SEC_MAX  = 32'd59;
  localparam int unsigned HR24_MAX = 32'd23;
  localparam int unsigned HR12_MIN = 32'd1;
  localparam int unsigned HR12_MAX = 32'd12;

  // Out-of-range inputs fold to 0 so the result is always a legal digit.
  function automatic bcd_nibble_t bcd_inc(input bcd_nibble_t d);
    if (d >= 4'd9) begin
      return 4'd0;
    end else begin
      return d + 4'd1;
    end
  endfunction

  // Out-of-range inputs fold to 9 so the result is always a legal digit.
  function automatic bcd_nibble_t bcd_dec(input bcd_nibble_t d);
    if ((d == 4'd0) || (d > 4'd9)) begin
      return 4'd9;
    end else begin
      return d - 4'd1;
    end
  endfunction

  function automatic logic [7:0] bin_to_bcd8(input int unsigned v);
    bcd_nibble_t t;
    bcd_nibble_t o;
    t = 4'((v / 32'd10) % 32'd10);
    o = 4'(v % 32'd10);
    return {t, o};
  endfunction

  function automatic logic bcd8_valid(input logic [7:0] v);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit register with up/down stepping, preset and wrap bounds.
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset (to RST_VAL)
//   load_i, load_val_i preset (highest priority)
//   up_i, down_i       step requests; both high cancels
//   min_i, max_i       wrap bounds: up at max_i -> min_i, down at min_i -> max_i
//   q_o                current digit
//   tc_up_o, tc_dn_o   digit sits at max_i / min_i
module bcd_digit
  import clock_pkg::*;
#(
  parameter bcd_nibble_t RST_VAL = 4'd0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        load_i,
  input  bcd_nibble_t load_val_i,
  input  logic        up_i,
  input  logic        down_i,
  input  bcd_nibble_t min_i,
  input  bcd_nibble_t max_i,
  output bcd_nibble_t q_o,
  output logic        tc_up_o,
  output logic        tc_dn_o
);

  bcd_nibble_t q_q;
  bcd_nibble_t q_d;

  // Next digit: preset, else a single-direction step with wrap, else hold.
  always_comb begin
    q_d = q_q;
    if (load_i) begin
      q_d = load_val_i;
    end else if (up_i && !down_i) begin
      q_d = (q_q == max_i) ? min_i : bcd_inc(q_q);
    end else if (down_i && !up_i) begin
      q_d = (q_q == min_i) ? max_i : bcd_dec(q_q);
    end else begin
      q_d = q_q;
    end
  end

  // Digit state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_q <= RST_VAL;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o     = q_q;
  assign tc_up_o = (q_q == max_i);
  assign tc_dn_o = (q_q == min_i);

endmodule

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD modulo counter over [MIN_VAL, MAX_VAL] for clock time fields.
// Ports:
//   clk, rst            clock, asynchronous active-low reset (value -> MIN_VAL)
//   en                  stage enable; low freezes state and clears load_err
//   inc, dec            level-sampled count requests (both high cancels)
//   load, load_val      validated synchronous preset, packed BCD {tens, ones}
//   tens, ones          current value
//   carry_out           combinational: up-wrap taken this cycle
//   borrow_out          combinational: down-wrap taken this cycle
//   load_err            registered one-cycle pulse after a rejected load
module bcd_mod_counter
  import clock_pkg::*;
#(
  parameter int unsigned MIN_VAL = 32'd0,
  parameter int unsigned MAX_VAL = HR24_MAX
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       inc,
  input  logic       dec,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       carry_out,
  output logic       borrow_out,
  output logic       load_err
);

  if ((MIN_VAL >= MAX_VAL) || (MAX_VAL > 32'd99)) begin : g_bad_range
    $fatal(1, "bcd_mod_counter: illegal range MIN_VAL=%0d MAX_VAL=%0d", MIN_VAL, MAX_VAL);
  end

  localparam logic [7:0] MIN_BCD = bin_to_bcd8(MIN_VAL);
  localparam logic [7:0] MAX_BCD = bin_to_bcd8(MAX_VAL);

  bcd_nibble_t tens_q;
  bcd_nibble_t ones_q;
  logic        load_err_q;
  logic        load_err_d;

  logic [7:0]  value_s;
  logic        at_max_s;
  logic        at_min_s;
  logic        up_s;
  logic        dn_s;
  logic        load_ok_s;
  logic        preset_s;
  logic [7:0]  preset_val_s;
  logic        ones_tc_up_s;
  logic        ones_tc_dn_s;
  logic        tens_tc_up_s;
  logic        tens_tc_dn_s;
  logic        ones_up_s;
  logic        ones_dn_s;
  logic        tens_up_s;
  logic        tens_dn_s;

  // Packed BCD keeps numeric order for legal digits, so range checks are
  // plain byte compares once both nibbles are known to be <= 9.
  assign value_s   = {tens_q, ones_q};
  assign at_max_s  = (value_s == MAX_BCD);
  assign at_min_s  = (value_s == MIN_BCD);
  assign up_s      = en & inc & ~dec & ~load;
  assign dn_s      = en & dec & ~inc & ~load;
  assign load_ok_s = en & load & bcd8_valid(load_val) &
                     (load_val >= MIN_BCD) & (load_val <= MAX_BCD);

  assign carry_out  = up_s & at_max_s;
  assign borrow_out = dn_s & at_min_s;

  // Range wraps reuse the digit preset path, so both digits jump together.
  assign preset_s = load_ok_s | carry_out | borrow_out;

  // Preset source: accepted load value, else the wrap target.
  always_comb begin
    preset_val_s = MIN_BCD;
    if (load_ok_s) begin
      preset_val_s = load_val;
    end else if (borrow_out) begin
      preset_val_s = MAX_BCD;
    end else begin
      preset_val_s = MIN_BCD;
    end
  end

  // Ordinary steps inside the range; tens only moves on a ones roll-over.
  // The tens terminal counts never gate in a legal range, they only stop a
  // tens digit from rolling past 9 or below 0.
  assign ones_up_s = up_s & ~at_max_s;
  assign ones_dn_s = dn_s & ~at_min_s;
  assign tens_up_s = ones_up_s & ones_tc_up_s & ~tens_tc_up_s;
  assign tens_dn_s = ones_dn_s & ones_tc_dn_s & ~tens_tc_dn_s;

  bcd_digit #(
    .RST_VAL (MIN_BCD[3:0])
  ) u_ones (
    .clk_i      (clk),
    .rst_ni     (rst),
    .load_i     (preset_s),
    .load_val_i (preset_val_s[3:0]),
    .up_i       (ones_up_s),
    .down_i     (ones_dn_s),
    .min_i      (4'd0),
    .max_i      (4'd9),
    .q_o        (ones_q),
    .tc_up_o    (ones_tc_up_s),
    .tc_dn_o    (ones_tc_dn_s)
  );

  bcd_digit #(
    .RST_VAL (MIN_BCD[7:4])
  ) u_tens (
    .clk_i      (clk),
    .rst_ni     (rst),
    .load_i     (preset_s),
    .load_val_i (preset_val_s[7:4]),
    .up_i       (tens_up_s),
    .down_i     (tens_dn_s),
    .min_i      (4'd0),
    .max_i      (4'd9),
    .q_o        (tens_q),
    .tc_up_o    (tens_tc_up_s),
    .tc_dn_o    (tens_tc_dn_s)
  );

  // A rejected load is any load request seen while enabled that fails checks.
  assign load_err_d = en & load & ~load_ok_s;

  // Error pulse register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      load_err_q <= 1'b0;
    end else begin
      load_err_q <= load_err_d;
    end
  end

  assign tens     = tens_q;
  assign ones     = ones_q;
  assign load_err = load_err_q;

endmodule

// File: tb/tb_bcd_mod_counter.sv
// Scoreboard bench: directed rows push hand-computed expectations; a negedge
// monitor pops and compares the addressed instance's outputs.
// Instances: 0 = 0..23, 1 = 1..12, 2 = 0..59, 3/4/5 = sec->min->hr chain.
module tb_bcd_mod_counter;
  import clock_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       en_s   [6];
  logic       inc_s  [6];
  logic       dec_s  [6];
  logic       load_s [6];
  logic [7:0] lv_s   [6];
  logic [3:0] tens_w [6];
  logic [3:0] ones_w [6];
  logic       cry_w  [6];
  logic       brw_w  [6];
  logic       err_w  [6];

  bcd_mod_counter u24 (
    .clk(clk), .rst(rst_n), .en(en_s[0]), .inc(inc_s[0]), .dec(dec_s[0]),
    .load(load_s[0]), .load_val(lv_s[0]), .tens(tens_w[0]), .ones(ones_w[0]),
    .carry_out(cry_w[0]), .borrow_out(brw_w[0]), .load_err(err_w[0]));

  bcd_mod_counter #(.MIN_VAL(HR12_MIN), .MAX_VAL(HR12_MAX)) u12 (
    .clk(clk), .rst(rst_n), .en(en_s[1]), .inc(inc_s[1]), .dec(dec_s[1]),
    .load(load_s[1]), .load_val(lv_s[1]), .tens(tens_w[1]), .ones(ones_w[1]),
    .carry_out(cry_w[1]), .borrow_out(brw_w[1]), .load_err(err_w[1]));

  bcd_mod_counter #(.MIN_VAL(32'd0), .MAX_VAL(SEC_MAX)) u60 (
    .clk(clk), .rst(rst_n), .en(en_s[2]), .inc(inc_s[2]), .dec(dec_s[2]),
    .load(load_s[2]), .load_val(lv_s[2]), .tens(tens_w[2]), .ones(ones_w[2]),
    .carry_out(cry_w[2]), .borrow_out(brw_w[2]), .load_err(err_w[2]));

  bcd_mod_counter #(.MIN_VAL(32'd0), .MAX_VAL(SEC_MAX)) u_sec (
    .clk(clk), .rst(rst_n), .en(en_s[3]), .inc(inc_s[3]), .dec(1'b0),
    .load(load_s[3]), .load_val(lv_s[3]), .tens(tens_w[3]), .ones(ones_w[3]),
    .carry_out(cry_w[3]), .borrow_out(brw_w[3]), .load_err(err_w[3]));

  bcd_mod_counter #(.MIN_VAL(32'd0), .MAX_VAL(SEC_MAX)) u_min (
    .clk(clk), .rst(rst_n), .en(en_s[3]), .inc(cry_w[3]), .dec(1'b0),
    .load(load_s[3]), .load_val(8'h59), .tens(tens_w[4]), .ones(ones_w[4]),
    .carry_out(cry_w[4]), .borrow_out(brw_w[4]), .load_err(err_w[4]));

  bcd_mod_counter #(.MIN_VAL(32'd0), .MAX_VAL(HR24_MAX)) u_hr (
    .clk(clk), .rst(rst_n), .en(en_s[3]), .inc(cry_w[4]), .dec(1'b0),
    .load(load_s[3]), .load_val(8'h23), .tens(tens_w[5]), .ones(ones_w[5]),
    .carry_out(cry_w[5]), .borrow_out(brw_w[5]), .load_err(err_w[5]));

  // Row: inputs for one cycle on one instance, plus the outputs expected at
  // that cycle's negedge (value before the edge, comb carry/borrow from these
  // inputs, load_err from the previous edge). same=1 adds a check in the
  // previous row's cycle without driving anything.
  typedef struct {
    int dut; bit rst; bit en; bit inc; bit dec; bit ld; logic [7:0] lv;
    logic [7:0] ev; bit ec; bit eb; bit ee; bit same; string nm;
  } row_t;

  typedef struct {
    int cyc; int dut; logic [7:0] ev; bit ec; bit eb; bit ee; string nm;
  } exp_t;

  row_t rows[$];
  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic add(input int dut, input bit rst, input bit en, input bit inc,
                     input bit dec, input bit ld, input logic [7:0] lv,
                     input logic [7:0] ev, input bit ec, input bit eb,
                     input bit ee, input bit same, input string nm);
    row_t r;
    r.dut = dut; r.rst = rst; r.en = en; r.inc = inc; r.dec = dec; r.ld = ld;
    r.lv = lv; r.ev = ev; r.ec = ec; r.eb = eb; r.ee = ee; r.same = same;
    r.nm = nm;
    rows.push_back(r);
  endtask

  task automatic drive(input row_t r);
    for (int i = 0; i < 6; i++) begin
      en_s[i] = 1'b0; inc_s[i] = 1'b0; dec_s[i] = 1'b0;
      load_s[i] = 1'b0; lv_s[i] = 8'h00;
    end
    rst_n = ~r.rst;
    en_s[r.dut] = r.en; inc_s[r.dut] = r.inc; dec_s[r.dut] = r.dec;
    load_s[r.dut] = r.ld; lv_s[r.dut] = r.lv;
  endtask

  // Monitor: compare every expectation due in the current cycle.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      exp_t e;
      logic [7:0] got;
      e = sb.pop_front();
      got = {tens_w[e.dut], ones_w[e.dut]};
      n_checks++;
      if (got === e.ev && cry_w[e.dut] === e.ec && brw_w[e.dut] === e.eb &&
          err_w[e.dut] === e.ee) begin
        n_pass++;
      end else begin
        $display("FAIL %s: dut%0d got value=%h carry=%b borrow=%b err=%b, expected value=%h carry=%b borrow=%b err=%b",
                 e.nm, e.dut, got, cry_w[e.dut], brw_w[e.dut], err_w[e.dut],
                 e.ev, e.ec, e.eb, e.ee);
      end
    end
  end

  initial begin
    for (int i = 0; i < 6; i++) begin
      en_s[i] = 1'b0; inc_s[i] = 1'b0; dec_s[i] = 1'b0;
      load_s[i] = 1'b0; lv_s[i] = 8'h00;
    end

    //   dut rst en inc dec ld lv     ev     c  b  e  same name
    add(0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, "reset_state");
    add(0, 0, 1, 0, 0, 1, 8'h17, 8'h00, 0, 0, 0, 0, "ld17");
    add(0, 0, 0, 0, 0, 0, 8'h00, 8'h17, 0, 0, 0, 0, "at17");
    add(0, 1, 1, 1, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, "rst_async");
    add(0, 0, 0, 1, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, "en0_inc_a");
    add(0, 0, 0, 1, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, "en0_inc_b");
    add(0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, "en0_held");
    add(0, 0, 1, 0, 0, 1, 8'h09, 8'h00, 0, 0, 0, 0, "ld09");
    add(0, 0, 1, 1, 0, 0, 8'h00, 8'h09, 0, 0, 0, 0, "inc09");
    add(0, 0, 0, 0, 0, 0, 8'h00, 8'h10, 0, 0, 0, 0, "at10");
    add(0, 0, 1, 0, 0, 1, 8'h23, 8'h10, 0, 0, 0, 0, "ld23");
    add(0, 0, 1, 1, 0, 0, 8'h00, 8'h23, 1, 0, 0, 0, "inc23_carry");
    add(0, 0, 1, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, "wrap00");
    add(0, 0, 1, 0, 1, 0, 8'h00, 8'h00, 0, 1, 0, 0, "dec00_borrow");
    add(0, 0, 0, 0, 0, 0, 8'h00, 8'h23, 0, 0, 0, 0, "wrap23");
    add(1, 0, 0, 0, 0, 0, 8'h00, 8'h01, 0, 0, 0, 0, "h12_reset");
    add(1, 0, 1, 0, 1, 0, 8'h00, 8'h01, 0, 1, 0, 0, "h12_dec01");
    add(1, 0, 1, 1, 0, 0, 8'h00, 8'h12, 1, 0, 0, 0, "h12_inc12");
    add(1, 0, 1, 0, 0, 1, 8'h10, 8'h01, 0, 0, 0, 0, "h12_ld10");
    add(1, 0, 1, 0, 1, 0, 8'h00, 8'h10, 0, 0, 0, 0, "h12_dec10");
    add(1, 0, 1, 0, 0, 1, 8'h00, 8'h09, 0, 0, 0, 0, "h12_ld00");
    add(1, 0, 0, 0, 0, 0, 8'h00, 8'h09, 0, 0, 1, 0, "h12_rej00");
    add(1, 0, 0, 0, 0, 0, 8'h00, 8'h09, 0, 0, 0, 0, "h12_errclr");
    add(2, 0, 1, 0, 0, 1, 8'h45, 8'h00, 0, 0, 0, 0, "m60_ld45");
    add(2, 0, 1, 0, 0, 1, 8'h60, 8'h45, 0, 0, 0, 0, "m60_ld60");
    add(2, 0, 1, 0, 0, 1, 8'h3A, 8'h45, 0, 0, 1, 0, "m60_ld3A");
    add(2, 0, 1, 1, 0, 1, 8'h30, 8'h45, 0, 0, 1, 0, "m60_ldinc");
    add(2, 0, 1, 0, 0, 1, 8'h59, 8'h30, 0, 0, 0, 0, "m60_ld59");
    add(2, 0, 1, 1, 1, 0, 8'h00, 8'h59, 0, 0, 0, 0, "m60_incdec");
    add(2, 0, 0, 0, 0, 1, 8'h12, 8'h59, 0, 0, 0, 0, "m60_en0_ld");
    add(2, 0, 0, 0, 0, 0, 8'h00, 8'h59, 0, 0, 0, 0, "m60_en0_chk");
    add(3, 0, 1, 0, 0, 1, 8'h59, 8'h00, 0, 0, 0, 0, "ch_ld_s");
    add(4, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 1, "ch_ld_m");
    add(5, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 1, "ch_ld_h");
    add(3, 0, 1, 1, 0, 0, 8'h00, 8'h59, 1, 0, 0, 0, "ch_inc_s");
    add(4, 0, 0, 0, 0, 0, 8'h00, 8'h59, 1, 0, 0, 1, "ch_inc_m");
    add(5, 0, 0, 0, 0, 0, 8'h00, 8'h23, 1, 0, 0, 1, "ch_inc_h");
    add(3, 0, 1, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, "ch_wrap_s");
    add(4, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 1, "ch_wrap_m");
    add(5, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 1, "ch_wrap_h");
    add(5, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, "ch_quiet_h");

    repeat (2) @(posedge clk);
    foreach (rows[k]) begin
      exp_t e;
      if (!rows[k].same) begin
        @(posedge clk);
        #1;
        drive(rows[k]);
      end
      e.cyc = cyc; e.dut = rows[k].dut; e.ev = rows[k].ev; e.ec = rows[k].ec;
      e.eb = rows[k].eb; e.ee = rows[k].ee; e.nm = rows[k].nm;
      sb.push_back(e);
    end

    repeat (3) @(posedge clk);
    n_checks++;
    if (sb.size() == 0) begin
      n_pass++;
    end else begin
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
